// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the multicycle MIPS controller.
//   Opcode constants, ALU/mux select encodings, the FSM state type and the
//   packed control vector driven to the datapath.
//   Optional feature macro: MULTICYCLE_BNE_EN (adds the BNEEX state and branchne).
package mips_pkg;

    localparam int unsigned STATE_W = 4;

    // Opcodes, IR[31:26]
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    // aluop encodings for the downstream ALU decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // alusrcb encodings
    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    // pcsrc encodings
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [STATE_W-1:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
`ifdef MULTICYCLE_BNE_EN
        JEX     = 4'd11,
        BNEEX   = 4'd12
`else
        JEX     = 4'd11
`endif
    } statetype;

    // Datapath control vector (everything except illegal, which depends on op)
    typedef struct packed {
        logic       iord;
        logic       irwrite;
        logic       pcwrite;
        logic       branch;
`ifdef MULTICYCLE_BNE_EN
        logic       branchne;
`endif
        logic [1:0] pcsrc;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       memwrite;
    } ctrl_t;

endpackage

// File: rtl/mc_outdec.sv
// mc_outdec: combinational decode from FSM state (plus memready) to the
//   datapath control vector.
//   Ports: state (in, statetype), memready (in, 1), ctrl (out, ctrl_t).
//   Optional feature macro: MULTICYCLE_BNE_EN (decodes BNEEX, drives branchne).
module mc_outdec (
    input  mips_pkg::statetype state,
    input  logic               memready,
    output mips_pkg::ctrl_t    ctrl
);
    import mips_pkg::*;

    // Every field defaults to 0 so unused outputs are never x
    always_comb begin
        ctrl = '0;
        case (state)
            FETCH: begin
                ctrl.iord    = 1'b0;
                ctrl.alusrca = 1'b0;
                ctrl.alusrcb = SRCB_FOUR;
                ctrl.aluop   = ALUOP_ADD;
                ctrl.pcsrc   = PCSRC_ALU;
                // IR and PC+4 commit only on the cycle memory delivers the word
                ctrl.irwrite = memready;
                ctrl.pcwrite = memready;
            end
            DECODE: begin
                ctrl.alusrca = 1'b0;
                ctrl.alusrcb = SRCB_IMMSH;
                ctrl.aluop   = ALUOP_ADD;
            end
            MEMADR, ADDIEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_IMM;
                ctrl.aluop   = ALUOP_ADD;
            end
            MEMRD: begin
                ctrl.iord = 1'b1;
            end
            MEMWB: begin
                ctrl.regdst   = 1'b0;
                ctrl.memtoreg = 1'b1;
                ctrl.regwrite = 1'b1;
            end
            MEMWR: begin
                ctrl.iord     = 1'b1;
                ctrl.memwrite = 1'b1;
            end
            RTYPEEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_B;
                ctrl.aluop   = ALUOP_FUNCT;
            end
            RTYPEWB: begin
                ctrl.regdst   = 1'b1;
                ctrl.memtoreg = 1'b0;
                ctrl.regwrite = 1'b1;
            end
            BEQEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_B;
                ctrl.aluop   = ALUOP_SUB;
                ctrl.pcsrc   = PCSRC_ALUOUT;
                ctrl.branch  = 1'b1;
            end
`ifdef MULTICYCLE_BNE_EN
            BNEEX: begin
                ctrl.alusrca  = 1'b1;
                ctrl.alusrcb  = SRCB_B;
                ctrl.aluop    = ALUOP_SUB;
                ctrl.pcsrc    = PCSRC_ALUOUT;
                ctrl.branch   = 1'b1;
                ctrl.branchne = 1'b1;
            end
`endif
            ADDIWB: begin
                ctrl.regdst   = 1'b0;
                ctrl.memtoreg = 1'b0;
                ctrl.regwrite = 1'b1;
            end
            JEX: begin
                ctrl.pcsrc   = PCSRC_JUMP;
                ctrl.pcwrite = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore FSM sequencing the multicycle MIPS datapath.
//   Holds the state register and next-state logic; output decode lives in mc_outdec.
//   Inputs : clk, reset (sync, active-high), op[5:0], memready.
//   Outputs: iord, irwrite, pcwrite, branch, pcsrc[1:0], alusrca, alusrcb[1:0],
//            aluop[1:0], regdst, memtoreg, regwrite, memwrite, illegal,
//            branchne (only with MULTICYCLE_BNE_EN), state[STATE_W-1:0] (debug).
//   Optional feature macro: MULTICYCLE_BNE_EN.
module multicycle_controller #(
    parameter int unsigned STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         op,
    input  logic               memready,
    output logic               iord,
    output logic               irwrite,
    output logic               pcwrite,
    output logic               branch,
    output logic [1:0]         pcsrc,
    output logic               alusrca,
    output logic [1:0]         alusrcb,
    output logic [1:0]         aluop,
    output logic               regdst,
    output logic               memtoreg,
    output logic               regwrite,
    output logic               memwrite,
`ifdef MULTICYCLE_BNE_EN
    output logic               branchne,
`endif
    output logic               illegal,
    output logic [STATE_W-1:0] state
);
    import mips_pkg::*;

    statetype state_q;
    statetype next_state;
    ctrl_t    ctrl_dec;
    ctrl_t    ctrl;

    mc_outdec u_outdec (
        .state    (state_q),
        .memready (memready),
        .ctrl     (ctrl_dec)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= next_state;
        end
    end

    // Next-state logic and reset gating of the control vector
    always_comb begin
        next_state = FETCH;
        illegal    = 1'b0;
        ctrl       = ctrl_dec;
        case (state_q)
            FETCH:   next_state = memready ? DECODE : FETCH;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: next_state = MEMADR;
                    OP_RTYPE:     next_state = RTYPEEX;
                    OP_BEQ:       next_state = BEQEX;
                    OP_ADDI:      next_state = ADDIEX;
                    OP_J:         next_state = JEX;
`ifdef MULTICYCLE_BNE_EN
                    OP_BNE:       next_state = BNEEX;
`else
                    OP_BNE: begin
                        next_state = FETCH;
                        illegal    = 1'b1;
                    end
`endif
                    default: begin
                        next_state = FETCH;
                        illegal    = 1'b1;
                    end
                endcase
            end
            MEMADR:  next_state = (op == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   next_state = memready ? MEMWB : MEMRD;
            MEMWB:   next_state = FETCH;
            MEMWR:   next_state = memready ? FETCH : MEMWR;
            RTYPEEX: next_state = RTYPEWB;
            RTYPEWB: next_state = FETCH;
            BEQEX:   next_state = FETCH;
`ifdef MULTICYCLE_BNE_EN
            BNEEX:   next_state = FETCH;
`endif
            ADDIEX:  next_state = ADDIWB;
            ADDIWB:  next_state = FETCH;
            JEX:     next_state = FETCH;
            default: next_state = FETCH;
        endcase
        // Reset suppresses every strobe and select so no partial write escapes
        if (reset) begin
            ctrl    = '0;
            illegal = 1'b0;
        end
    end

    assign iord     = ctrl.iord;
    assign irwrite  = ctrl.irwrite;
    assign pcwrite  = ctrl.pcwrite;
    assign branch   = ctrl.branch;
    assign pcsrc    = ctrl.pcsrc;
    assign alusrca  = ctrl.alusrca;
    assign alusrcb  = ctrl.alusrcb;
    assign aluop    = ctrl.aluop;
    assign regdst   = ctrl.regdst;
    assign memtoreg = ctrl.memtoreg;
    assign regwrite = ctrl.regwrite;
    assign memwrite = ctrl.memwrite;
`ifdef MULTICYCLE_BNE_EN
    assign branchne = ctrl.branchne;
`endif
    assign state    = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: self-checking bench for multicycle_controller.
//   Reference model: per-opcode step list plus a per-step output table, with
//   memready stalls injected on memory steps. Directed cases then random traffic.
//   Optional feature macro: MULTICYCLE_BNE_EN.
module tb_multicycle_controller;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic       memready;
    logic       iord, irwrite, pcwrite, branch;
    logic [1:0] pcsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic       regdst, memtoreg, regwrite, memwrite, illegal;
    logic [3:0] state;
`ifdef MULTICYCLE_BNE_EN
    logic       branchne;
`endif

    int tests = 0;
    int fails = 0;

    typedef enum int {
        T_FETCH, T_DECODE, T_MEMADR, T_MEMRD, T_MEMWB, T_MEMWR,
        T_RTEX, T_RTWB, T_BEQ, T_BNE, T_ADDIEX, T_ADDIWB, T_JEX, T_RESET
    } tstep_t;

    multicycle_controller #(.STATE_W(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .op       (op),
        .memready (memready),
        .iord     (iord),
        .irwrite  (irwrite),
        .pcwrite  (pcwrite),
        .branch   (branch),
        .pcsrc    (pcsrc),
        .alusrca  (alusrca),
        .alusrcb  (alusrcb),
        .aluop    (aluop),
        .regdst   (regdst),
        .memtoreg (memtoreg),
        .regwrite (regwrite),
        .memwrite (memwrite),
`ifdef MULTICYCLE_BNE_EN
        .branchne (branchne),
`endif
        .illegal  (illegal),
        .state    (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed vector: {iord,irwrite,pcwrite,branch,pcsrc,alusrca,alusrcb,aluop,regdst,memtoreg,regwrite,memwrite,illegal}
    logic [15:0] obs;
    assign obs = {iord, irwrite, pcwrite, branch, pcsrc, alusrca, alusrcb, aluop,
                  regdst, memtoreg, regwrite, memwrite, illegal};

    function automatic logic [15:0] mk(input logic io, input logic irw, input logic pcw,
                                       input logic br, input logic [1:0] pcs, input logic asa,
                                       input logic [1:0] asb, input logic [1:0] aop,
                                       input logic rd, input logic m2r, input logic rw,
                                       input logic mw, input logic ill);
        return {io, irw, pcw, br, pcs, asa, asb, aop, rd, m2r, rw, mw, ill};
    endfunction

    // Expected outputs per step, straight from the behaviour table
    function automatic logic [15:0] expect_vec(input tstep_t s, input logic mr, input logic bad_op);
        case (s)
            T_FETCH:  return mk(1'b0, mr, mr, 1'b0, 2'b00, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            T_DECODE: return mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, bad_op);
            T_MEMADR: return mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            T_MEMRD:  return mk(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            T_MEMWB:  return mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
            T_MEMWR:  return mk(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            T_RTEX:   return mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            T_RTWB:   return mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
            T_BEQ,
            T_BNE:    return mk(1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b1, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            T_ADDIEX: return mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            T_ADDIWB: return mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            T_JEX:    return mk(1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            default:  return 16'h0000;
        endcase
    endfunction

    function automatic bit is_mem(input tstep_t s);
        return (s == T_FETCH) || (s == T_MEMRD) || (s == T_MEMWR);
    endfunction

    task automatic check(input string tag, input tstep_t s, input logic [15:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s step=%0d observed=%h expected=%h", tag, s, obs, exp_v);
        end
`ifdef MULTICYCLE_BNE_EN
        tests++;
        assert (branchne === (s == T_BNE)) else begin
            fails++;
            $error("FAIL %s_branchne step=%0d observed=%b expected=%b", tag, s, branchne, (s == T_BNE));
        end
`endif
    endtask

    // Run one instruction through the model; fetch_stalls/mem_stalls < 0 means random.
    // abort_idx >= 0 asserts reset on that step instead of completing it.
    task automatic run_instr(input string tag, input logic [5:0] opc, input int fetch_stalls,
                             input int mem_stalls, input int abort_idx);
        tstep_t plan[$];
        int     target;
        int     stalls;
        logic   mr;
        bit     bad;
        bit     done;
        plan.push_back(T_FETCH);
        plan.push_back(T_DECODE);
        case (opc)
            6'b100011: begin plan.push_back(T_MEMADR); plan.push_back(T_MEMRD); plan.push_back(T_MEMWB); end
            6'b101011: begin plan.push_back(T_MEMADR); plan.push_back(T_MEMWR); end
            6'b000000: begin plan.push_back(T_RTEX); plan.push_back(T_RTWB); end
            6'b000100: plan.push_back(T_BEQ);
            6'b001000: begin plan.push_back(T_ADDIEX); plan.push_back(T_ADDIWB); end
            6'b000010: plan.push_back(T_JEX);
`ifdef MULTICYCLE_BNE_EN
            6'b000101: plan.push_back(T_BNE);
`endif
            default: ;
        endcase
        bad = (plan.size() == 2);
        for (int i = 0; i < plan.size(); i++) begin
            if (plan[i] == T_FETCH)
                target = (fetch_stalls < 0) ? int'($urandom_range(0, 2)) : fetch_stalls;
            else
                target = (mem_stalls < 0) ? int'($urandom_range(0, 2)) : mem_stalls;
            stalls = 0;
            done   = 1'b0;
            for (int c = 0; c < 8 && !done; c++) begin
                @(negedge clk);
                op = (plan[i] == T_FETCH) ? 6'($urandom) : opc;
                if (i == abort_idx) begin
                    reset    = 1'b1;
                    memready = 1'b1;
                    #1 check({tag, "_reset"}, T_RESET, 16'h0000);
                    return;
                end
                reset = 1'b0;
                if (is_mem(plan[i]))
                    mr = (stalls < target) ? 1'b0 : 1'b1;
                else
                    mr = 1'($urandom_range(0, 1));
                memready = mr;
                #1 check(tag, plan[i], expect_vec(plan[i], mr, bad));
                if (is_mem(plan[i]) && !mr)
                    stalls++;
                else
                    done = 1'b1;
            end
        end
    endtask

    logic [5:0] legal_ops [7];
    logic [5:0] rop;

    initial begin
        legal_ops[0] = 6'b100011; legal_ops[1] = 6'b101011; legal_ops[2] = 6'b000000;
        legal_ops[3] = 6'b000100; legal_ops[4] = 6'b001000; legal_ops[5] = 6'b000010;
        legal_ops[6] = 6'b000101;
        reset    = 1'b1;
        op       = 6'b000000;
        memready = 1'b1;

        // Reset held: everything forced low even with memready high
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            memready = 1'b1;
            op       = 6'($urandom);
            #1 check("reset_hold", T_RESET, 16'h0000);
        end

        run_instr("lw_nostall", 6'b100011, 0, 0, -1);
        run_instr("sw_memwr_stall2", 6'b101011, 0, 2, -1);
        run_instr("rtype_b2b", 6'b000000, 0, 0, -1);
        run_instr("beq_b2b", 6'b000100, 0, 0, -1);
        run_instr("fetch_stall3", 6'b001000, 3, 0, -1);
        run_instr("illegal_op", 6'b111111, 0, 0, -1);
        run_instr("lw_reset_in_memrd", 6'b100011, 0, 1, 3);
        run_instr("after_reset_j", 6'b000010, 0, 0, -1);
        run_instr("op_bne", 6'b000101, 0, 0, -1);
        run_instr("sw_nostall", 6'b101011, 0, 0, -1);

        // Random traffic, with occasional mid-instruction reset
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 7) == 0)
                rop = 6'($urandom);
            else
                rop = legal_ops[$urandom_range(0, 6)];
            run_instr("random", rop, -1, -1,
                      ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 4)) : -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
